cve2_dummy_instr_burst: RTL and testbench
=========================================

# cve2_dummy_instr_burst

Parametrised dummy-instruction generator for the CVE2 IF stage. It pseudo-randomly inserts bursts of fake R-type ALU/MUL/DIV instructions writing x0 into the fetch stream to obfuscate control flow and timing. Counter width, burst length and the set of enabled instruction types are configurable. The block owns its own seeded LFSR.

## Interface
- `CntW`, 5: width of the inter-insertion counter; ≥4.
- `BurstW`, 2: width of the burst field; max burst = 2^BurstW.
- `LfsrW`, 32: LFSR width; must be ≥ CntW+12+BurstW.
- `TypeEn`, 4'b1111: per-type enable, bit0 ADD, bit1 MUL, bit2 DIV, bit3 AND.
- `RndCnstLfsrSeed`, 32'hACE1_2345: LFSR reset value; zero is illegal.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `dummy_instr_en_i` in 1: CSR enable.
- `dummy_instr_mask_i` in 3: CSR mask on the top 3 bits of the threshold.
- `dummy_burst_mask_i` in BurstW: CSR mask on the burst field.
- `dummy_instr_seed_en_i` in 1: seed write strobe.
- `dummy_instr_seed_i` in 32: seed write data.
- `fetch_valid_i` in 1: real instruction valid from IF.
- `id_in_ready_i` in 1: ID accepts this cycle.
- `insert_dummy_instr_o` out 1: dummy valid. Reset value 0.
- `dummy_instr_data_o` out 32: dummy encoding. Reset value is derived from the reset LFSR state.
- `dummy_instr_cnt_o` out 16: saturating count of accepted dummies. Reset value 0.

## Operation
- Seed register: `seed_q <= seed_q ^ dummy_instr_seed_i` on strobe. The LFSR loads the same XOR value in that cycle.
- LFSR (Galois, right shift): `next = (s>>1) ^ (s[0] ? 32'h8020_0003 : 0)`.
  - A zero load is forced to 32'h1.
  - Seed load takes priority over the shift.
  - The LFSR shifts on every accepted dummy (`insert_dummy_instr_o & id_in_ready_i`).
- LFSR fields, LSB first:
  - `cnt` = s[CntW-1:0]
  - `op_a` = next 5 bits
  - `op_b` = next 5 bits
  - `type` = next 2 bits
  - `burst` = next BurstW bits
- Threshold = `cnt & {mask_i, {CntW-3{1'b1}}}`.
- Burst length = 1 + (`burst & dummy_burst_mask_i`). It is latched on entry to INSERT.
- Type remap: a type whose `TypeEn` bit is 0 encodes as ADD.
- Encoding: `{funct7, op_b, op_a, funct3, 5'h00, 7'h33}`.
  - ADD: funct7 0, funct3 000
  - MUL: funct7 1, funct3 000
  - DIV: funct7 1, funct3 100
  - AND: funct7 0, funct3 111
- FSM:
  - IDLE: `cnt_q` increments on `en & fetch_valid_i & id_in_ready_i`. The transition to INSERT happens when `en & cnt_q == threshold`.
  - INSERT: `insert_dummy_instr_o`=1 and `burst_left` is loaded.
    - Each accepted dummy decrements `burst_left`.
    - On the last accept, go to IDLE and clear `cnt_q`.
    - `en` low: go to IDLE next cycle and clear `cnt_q`. A handshake in the current cycle still counts.
- `dummy_instr_cnt_o` increments per accepted dummy and saturates at 16'hFFFF.

## Timing
- Threshold match in IDLE: `insert_dummy_instr_o` rises the next cycle. The output is registered FSM state with no combinational path from inputs.
- `dummy_instr_data_o` is combinational from the current LFSR state. It updates the cycle after each accept, so each burst entry carries a fresh instruction.
- `id_in_ready_i` low in INSERT: output and data are held stable.
- Seed strobe mid-burst: the LFSR reloads, `burst_left` is unaffected, and the next dummy uses new fields.
- `cnt_q` wraps modulo 2^CntW. It cannot miss because threshold < 2^CntW.
- Reset mid-burst: return to IDLE, `cnt_q`=0, LFSR=RndCnstLfsrSeed, `seed_q`=0.

## Configuration
- `CVE2_DUMMY_INSTR_BURST_EN` defined: burst behaviour as above.
- Undefined: burst length is fixed at 1 and `dummy_burst_mask_i` is ignored. The `burst_left` counter and its logic are not instantiated. The port remains.

## Structure
- `cve2_pkg` holds:
  - `dummy_instr_e` (ADD/MUL/DIV/AND)
  - `dummy_fsm_e` (IDLE/INSERT)
  - default seed constant
  - LFSR polynomial constant
- One sub-module, `cve2_dummy_lfsr`: Galois LFSR with seed load, zero-lock guard and enable.

## Test plan
- Seed write 32'h1 (`seed_q`=0), en=1, mask=3'b111, burst_mask=0.
  - After 1 accepted fetch, `insert_dummy_instr_o`=1 next cycle and data=32'h0000_0033.
  - After accept, LFSR=32'h8020_0003 and the next threshold is 3.
- Same seed, `TypeEn`=4'b0001, random seeds for 1000 dummies.
  - Required: funct7=0, funct3=000, rd=0, opcode=7'h33 on all of them.
- burst_mask=2'b11 with a seed giving burst field 3.
  - Required: 4 consecutive dummies, each with distinct data.
  - Required: `dummy_instr_cnt_o` advances by 4.
  - Macro undefined: exactly 1 dummy.
- Hold `id_in_ready_i`=0 for 5 cycles during INSERT.
  - Required: output and data stable, LFSR unchanged.
- Deassert en mid-burst.
  - Required: `insert_dummy_instr_o`=0 next cycle and `cnt_q`=0.
  - Seed with 32'h0 while `seed_q`=0: LFSR=32'h1.
- Assert `rst_ni` mid-burst.
  - Required: all outputs reset and LFSR=RndCnstLfsrSeed.

Source files
------------

// File: rtl/cve2_dummy_instr_burst_pkg.sv
// Shared types and constants for the CVE2 dummy-instruction burst generator.
// Optional burst support is selected in the top by CVE2_DUMMY_INSTR_BURST_EN.
package cve2_dummy_instr_burst_pkg;

  typedef enum logic [1:0] {
    DUMMY_ADD = 2'b00,
    DUMMY_MUL = 2'b01,
    DUMMY_DIV = 2'b10,
    DUMMY_AND = 2'b11
  } dummy_instr_e;

  typedef enum logic {
    FSM_IDLE   = 1'b0,
    FSM_INSERT = 1'b1
  } dummy_fsm_e;

  localparam logic [31:0] DummyLfsrSeedDefault = 32'hACE1_2345;
  localparam logic [31:0] DummyLfsrPoly        = 32'h8020_0003;

  // R-type encoding with rd = x0 so the dummy never changes architectural state
  function automatic logic [31:0] dummy_encode(input dummy_instr_e t,
                                               input logic [4:0]   rs1,
                                               input logic [4:0]   rs2);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = 7'h00;
    f3 = 3'b000;
    case (t)
      DUMMY_MUL: f7 = 7'h01;
      DUMMY_DIV: begin
        f7 = 7'h01;
        f3 = 3'b100;
      end
      DUMMY_AND: f3 = 3'b111;
      default: ;
    endcase
    return {f7, rs2, rs1, f3, 5'h00, 7'h33};
  endfunction

endpackage

// File: rtl/cve2_dummy_lfsr.sv
// Galois right-shift LFSR with seed load (priority over shift) and a guard
// that turns an all-zero load into 1 so the register can never lock up.
module cve2_dummy_lfsr
  import cve2_dummy_instr_burst_pkg::*;
#(
  parameter int unsigned       LfsrW = 32,
  parameter logic [LfsrW-1:0]  Seed  = LfsrW'(DummyLfsrSeedDefault)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [LfsrW-1:0] i_load_val,
  output logic [LfsrW-1:0] o_state
);

  logic [LfsrW-1:0] r_state;
  logic [LfsrW-1:0] w_next;

  always_comb begin
    w_next = r_state;
    if (i_load) begin
      w_next = (i_load_val == '0) ? LfsrW'(1) : i_load_val;
    end else if (i_en) begin
      w_next = (r_state >> 1) ^ (r_state[0] ? LfsrW'(DummyLfsrPoly) : '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= Seed;
    else         r_state <= w_next;
  end

  assign o_state = r_state;

endmodule

// File: rtl/cve2_dummy_instr_burst.sv
// Dummy-instruction generator for the IF stage: inserts bursts of x0-writing
// ALU/MUL/DIV ops. Multi-dummy bursts exist only with CVE2_DUMMY_INSTR_BURST_EN.
module cve2_dummy_instr_burst
  import cve2_dummy_instr_burst_pkg::*;
#(
  parameter int unsigned CntW            = 5,
  parameter int unsigned BurstW          = 2,
  parameter int unsigned LfsrW           = 32,
  parameter logic [3:0]  TypeEn          = 4'b1111,
  parameter logic [31:0] RndCnstLfsrSeed = DummyLfsrSeedDefault
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dummy_instr_en_i,
  input  logic [2:0]        dummy_instr_mask_i,
  input  logic [BurstW-1:0] dummy_burst_mask_i,
  input  logic              dummy_instr_seed_en_i,
  input  logic [31:0]       dummy_instr_seed_i,
  input  logic              fetch_valid_i,
  input  logic              id_in_ready_i,
  output logic              insert_dummy_instr_o,
  output logic [31:0]       dummy_instr_data_o,
  output logic [15:0]       dummy_instr_cnt_o
);

  localparam logic [0:0] StIdle   = FSM_IDLE;
  localparam logic [0:0] StInsert = FSM_INSERT;

  logic [0:0]        r_state;
  logic [CntW-1:0]   r_cnt;
  logic [31:0]       r_seed;
  logic [15:0]       r_dummy_cnt;
  logic [LfsrW-1:0]  w_lfsr;
  logic              w_accept;
  logic              w_go;
  logic              w_last;
  logic [CntW-1:0]   w_cnt_fld;
  logic [CntW-1:0]   w_thresh;
  logic [4:0]        w_op_a;
  logic [4:0]        w_op_b;
  logic [1:0]        w_type;
  logic [BurstW-1:0] w_burst;
  dummy_instr_e      w_type_eff;
  logic              w_unused_lfsr;

  assign w_cnt_fld = w_lfsr[CntW-1:0];
  assign w_op_a    = w_lfsr[CntW+4 -: 5];
  assign w_op_b    = w_lfsr[CntW+9 -: 5];
  assign w_type    = w_lfsr[CntW+11 -: 2];
  assign w_burst   = w_lfsr[CntW+12+BurstW-1 -: BurstW];
  assign w_unused_lfsr = ^w_lfsr;

  // Masking keeps threshold < 2^CntW, so the wrapping counter always meets it
  assign w_thresh = w_cnt_fld & {dummy_instr_mask_i, {(CntW-3){1'b1}}};

  assign w_type_eff = TypeEn[w_type] ? dummy_instr_e'(w_type) : DUMMY_ADD;

  assign insert_dummy_instr_o = (r_state == StInsert);
  assign dummy_instr_data_o   = dummy_encode(w_type_eff, w_op_a, w_op_b);
  assign dummy_instr_cnt_o    = r_dummy_cnt;

  assign w_accept = insert_dummy_instr_o & id_in_ready_i;
  assign w_go     = (r_state == StIdle) & dummy_instr_en_i & (r_cnt == w_thresh);

  cve2_dummy_lfsr #(
    .LfsrW (LfsrW),
    .Seed  (LfsrW'(RndCnstLfsrSeed))
  ) u_lfsr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_en       (w_accept),
    .i_load     (dummy_instr_seed_en_i),
    .i_load_val (LfsrW'(r_seed ^ dummy_instr_seed_i)),
    .o_state    (w_lfsr)
  );

`ifdef CVE2_DUMMY_INSTR_BURST_EN
  logic [BurstW-1:0] r_burst_left;

  // Holds the number of dummies still owed after the current one
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_burst_left <= '0;
    end else if (w_go) begin
      r_burst_left <= w_burst & dummy_burst_mask_i;
    end else if (w_accept && (r_burst_left != '0)) begin
      r_burst_left <= r_burst_left - BurstW'(1);
    end
  end

  assign w_last = (r_burst_left == '0);
`else
  logic w_unused_burst;
  assign w_unused_burst = ^{dummy_burst_mask_i, w_burst};
  assign w_last         = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (dummy_instr_en_i && fetch_valid_i && id_in_ready_i) r_cnt <= r_cnt + CntW'(1);
          if (w_go) r_state <= StInsert;
        end
        StInsert: begin
          if (!dummy_instr_en_i || (w_accept && w_last)) begin
            r_state <= StIdle;
            r_cnt   <= '0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_seed      <= '0;
      r_dummy_cnt <= '0;
    end else begin
      if (dummy_instr_seed_en_i) r_seed <= r_seed ^ dummy_instr_seed_i;
      if (w_accept && (r_dummy_cnt != 16'hFFFF)) r_dummy_cnt <= r_dummy_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cve2_dummy_instr_burst.sv
// Directed bench for cve2_dummy_instr_burst; burst expectations follow
// whether CVE2_DUMMY_INSTR_BURST_EN is defined for the build.
module tb_cve2_dummy_instr_burst;

  logic        clk_i  = 1'b0;
  logic        rst_ni = 1'b1;
  logic        en, seed_en, fetch, ready;
  logic [2:0]  mask;
  logic [1:0]  bmask;
  logic [31:0] seed;
  logic        insert;
  logic [31:0] data;
  logic [15:0] dcnt;

  logic        a_en, a_seed_en, a_fetch, a_ready;
  logic [2:0]  a_mask;
  logic [1:0]  a_bmask;
  logic [31:0] a_seed;
  logic        a_insert;
  logic [31:0] a_data;
  logic [15:0] a_cnt;

  int n_vec = 0;
  int n_err = 0;
  int n_dummy = 0;
  int cyc = 0;
  int exp_cnt = 0;

  localparam logic [31:0] T = 32'h0006_0000;

  always #5 clk_i = ~clk_i;

  cve2_dummy_instr_burst u_dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .dummy_instr_en_i      (en),
    .dummy_instr_mask_i    (mask),
    .dummy_burst_mask_i    (bmask),
    .dummy_instr_seed_en_i (seed_en),
    .dummy_instr_seed_i    (seed),
    .fetch_valid_i         (fetch),
    .id_in_ready_i         (ready),
    .insert_dummy_instr_o  (insert),
    .dummy_instr_data_o    (data),
    .dummy_instr_cnt_o     (dcnt)
  );

  cve2_dummy_instr_burst #(.TypeEn(4'b0001)) u_dut_add (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .dummy_instr_en_i      (a_en),
    .dummy_instr_mask_i    (a_mask),
    .dummy_burst_mask_i    (a_bmask),
    .dummy_instr_seed_en_i (a_seed_en),
    .dummy_instr_seed_i    (a_seed),
    .fetch_valid_i         (a_fetch),
    .id_in_ready_i         (a_ready),
    .insert_dummy_instr_o  (a_insert),
    .dummy_instr_data_o    (a_data),
    .dummy_instr_cnt_o     (a_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    en = 0; seed_en = 0; fetch = 0; ready = 0; mask = 3'b000; bmask = 2'b00; seed = '0;
    a_en = 0; a_seed_en = 0; a_fetch = 0; a_ready = 0; a_mask = 3'b000; a_bmask = 2'b00; a_seed = '0;
    #2 rst_ni = 1'b0;
    step();
    step();
    chk("rst_insert", 32'(insert), 0);
    chk("rst_cnt", 32'(dcnt), 0);
    chk("rst_data", data, 32'h028D_4033);
    chk("rst_lfsr", u_dut.w_lfsr, 32'hACE1_2345);
    rst_ni = 1'b1;
    step();

    // seed 1 -> LFSR 1, threshold 1
    seed_en = 1; seed = 32'h1; en = 1; mask = 3'b111; bmask = 2'b00; ready = 1;
    step();
    seed_en = 0; seed = '0;
    chk("seed1_lfsr", u_dut.w_lfsr, 32'h1);
    chk("seed1_insert", 32'(insert), 0);
    fetch = 1;
    step();
    fetch = 0; ready = 0;
    chk("fetch1_cntq", 32'(u_dut.r_cnt), 1);
    chk("fetch1_insert", 32'(insert), 0);
    step();
    chk("thr1_insert", 32'(insert), 1);
    chk("thr1_data", data, 32'h0000_0033);
    repeat (5) begin
      step();
      chk("hold_insert", 32'(insert), 1);
      chk("hold_data", data, 32'h0000_0033);
      chk("hold_lfsr", u_dut.w_lfsr, 32'h1);
    end
    ready = 1;
    step();
    chk("acc1_insert", 32'(insert), 0);
    chk("acc1_lfsr", u_dut.w_lfsr, 32'h8020_0003);
    chk("acc1_cnt", 32'(dcnt), 1);
    chk("acc1_cntq", 32'(u_dut.r_cnt), 0);

    // threshold 3 needs exactly three accepted fetches
    fetch = 1;
    repeat (3) step();
    fetch = 0;
    chk("thr3_cntq", 32'(u_dut.r_cnt), 3);
    chk("thr3_pre_insert", 32'(insert), 0);
    step();
    chk("thr3_insert", 32'(insert), 1);
    chk("thr3_data", data, 32'h0000_0033);
    step();
    chk("acc2_insert", 32'(insert), 0);
    chk("acc2_lfsr", u_dut.w_lfsr, 32'hC030_0002);
    chk("acc2_cnt", 32'(dcnt), 2);

    // burst field 3 with full burst mask
    bmask = 2'b11;
    seed_en = 1; seed = T ^ 32'h1;
    step();
    seed_en = 0; seed = '0;
    chk("burst_lfsr", u_dut.w_lfsr, T);
    chk("burst_pre_insert", 32'(insert), 0);
    step();
    chk("burst0_insert", 32'(insert), 1);
    chk("burst0_data", data, 32'h0000_0033);
`ifdef CVE2_DUMMY_INSTR_BURST_EN
    step();
    chk("burst1_insert", 32'(insert), 1);
    chk("burst1_data", data, 32'h0200_4033);
    step();
    chk("burst2_insert", 32'(insert), 1);
    chk("burst2_data", data, 32'h0000_7033);
    step();
    chk("burst3_insert", 32'(insert), 1);
    chk("burst3_data", data, 32'h0300_0033);
    step();
    chk("burst_end_insert", 32'(insert), 0);
    chk("burst_end_lfsr", u_dut.w_lfsr, 32'h0000_6000);
    exp_cnt = 6;
`else
    step();
    chk("single_end_insert", 32'(insert), 0);
    chk("single_end_data", data, 32'h0200_4033);
    exp_cnt = 3;
`endif
    chk("burst_cnt", 32'(dcnt), 32'(exp_cnt));
    chk("burst_cntq", 32'(u_dut.r_cnt), 0);
    en = 0;
    step();
    chk("en_off_insert", 32'(insert), 0);

    // seed_q back to 0, then zero loads must give LFSR 1
    seed_en = 1; seed = T;
    step();
    chk("seedq_zero", u_dut.r_seed, 0);
    chk("zero_load_lfsr_a", u_dut.w_lfsr, 32'h1);
    seed = '0;
    step();
    seed_en = 0;
    chk("zero_load_lfsr_b", u_dut.w_lfsr, 32'h1);

    // en dropped in INSERT with handshake in the same cycle
    seed_en = 1; seed = T; en = 1;
    step();
    seed_en = 0; seed = '0;
    chk("en_lfsr", u_dut.w_lfsr, T);
    step();
    chk("en_insert", 32'(insert), 1);
    en = 0;
    step();
    exp_cnt++;
    chk("en_drop_insert", 32'(insert), 0);
    chk("en_drop_cntq", 32'(u_dut.r_cnt), 0);
    chk("en_drop_lfsr", u_dut.w_lfsr, 32'h0003_0000);
    chk("en_drop_cnt", 32'(dcnt), 32'(exp_cnt));

    // async reset while inserting
    en = 1;
    step();
    chk("rst2_pre_insert", 32'(insert), 1);
    step();
    rst_ni = 1'b0;
    #1;
    chk("rst2_insert", 32'(insert), 0);
    chk("rst2_cnt", 32'(dcnt), 0);
    chk("rst2_lfsr", u_dut.w_lfsr, 32'hACE1_2345);
    chk("rst2_data", data, 32'h028D_4033);
    chk("rst2_cntq", 32'(u_dut.r_cnt), 0);
    chk("rst2_seedq", u_dut.r_seed, 0);
    en = 0;
    step();
    rst_ni = 1'b1;
    step();

    // ADD-only instance, random reseeds
    a_en = 1; a_fetch = 1; a_ready = 1;
    while (n_dummy < 1000 && cyc < 20000) begin
      a_seed_en = 0;
      if (a_insert) begin
        chk("add_only_fields", 32'({a_data[31:25], a_data[14:12], a_data[11:7], a_data[6:0]}),
            32'({7'h00, 3'b000, 5'h00, 7'h33}));
        n_dummy++;
        if (n_dummy % 8 == 0) begin
          a_seed_en = 1;
          a_seed = $urandom;
        end
      end
      step();
      cyc++;
    end
    a_seed_en = 0;
    chk("add_budget", 32'(n_dummy), 1000);
    chk("add_cnt", 32'(a_cnt), 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
